// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared types and helpers for the AES-128 key-schedule controller.
//   aes_byte    : one AES byte (also the round-constant width)
//   rnd_idx_t   : round-key index 0..AES_NR
//   ks_state_e  : controller states
//   xtime()     : GF(2^8) multiply-by-two used to advance the round constant
package aes_key_sched_ctrl_pkg;

    typedef logic [7:0] aes_byte;
    typedef logic [3:0] rnd_idx_t;

    localparam int      AES_NR    = 10;
    localparam aes_byte RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        KS_IDLE    = 3'd0,
        KS_RK0     = 3'd1,
        KS_STEP    = 3'd2,
        KS_PRESENT = 3'd3,
        KS_DONE    = 3'd4
    } ks_state_e;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic aes_byte xtime(input aes_byte b);
        aes_byte shifted;
        shifted = {b[6:0], 1'b0};
        if (b[7]) begin
            xtime = shifted ^ 8'h1B;
        end else begin
            xtime = shifted;
        end
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_rcon.sv
// Round-constant register for the key-schedule controller.
// Ports:
//   clk, nrst : clock, synchronous active-low reset
//   load_i    : reload the register with RCON_INIT_VAL
//   adv_i     : advance the register by xtime (ignored when load_i is high)
//   rcon_o    : current round constant
module aes_rcon_gen
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter aes_byte RCON_INIT_VAL = 8'h01
) (
    input  logic    clk,
    input  logic    nrst,
    input  logic    load_i,
    input  logic    adv_i,
    output aes_byte rcon_o
);

    aes_byte rcon_q;

    // Round-constant register: reset/load to the initial value, or step by xtime.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rcon_q <= RCON_INIT_VAL;
        end else if (load_i) begin
            rcon_q <= RCON_INIT_VAL;
        end else if (adv_i) begin
            rcon_q <= xtime(rcon_q);
        end else begin
            rcon_q <= rcon_q;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES-128 key-generation datapath. Steps the key generator
// one round per STEP cycle and presents each round key 0..NUM_ROUNDS to the
// cipher core with a valid/ready handshake, stalling while the consumer is busy.
// Ports:
//   clk, nrst         : clock, synchronous active-low reset
//   start, abort      : begin a schedule (IDLE only) / cancel it
//   busy, done        : activity flag / one-cycle completion pulse
//   kg_en, kg_gen_key : key-generator step strobe and rcon-select
//   kg_next_rnd       : 0 = expand from cipher key, 1 = from registered key
//   kg_rcon           : round constant for the current step
//   rk_valid/rk_ready : round-key handshake; rk_idx/rk_is_init describe the key
// All outputs are decodes of registered state only.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int          NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       kg_en,
    output logic       kg_gen_key,
    output logic       kg_next_rnd,
    output logic [7:0] kg_rcon,
    output logic       rk_valid,
    input  logic       rk_ready,
    output logic [3:0] rk_idx,
    output logic       rk_is_init
);

    ks_state_e state_q, state_d;
    rnd_idx_t  cnt_q, cnt_d;
    logic      rcon_load_s;
    logic      rcon_adv_s;
    aes_byte   rcon_s;

    aes_rcon_gen #(
        .RCON_INIT_VAL (RCON_INIT)
    ) u_rcon (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (rcon_load_s),
        .adv_i  (rcon_adv_s),
        .rcon_o (rcon_s)
    );

    // State and round-counter registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= KS_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcon_load_s = 1'b0;
        rcon_adv_s  = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (start && !abort) begin
                    state_d     = KS_RK0;
                    cnt_d       = 4'd0;
                    rcon_load_s = 1'b1;
                end else begin
                    state_d = KS_IDLE;
                end
            end
            KS_RK0: begin
                if (abort) begin
                    state_d = KS_IDLE;
                end else if (rk_ready) begin
                    state_d = KS_STEP;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = KS_RK0;
                end
            end
            KS_STEP: begin
                if (abort) begin
                    state_d = KS_IDLE;
                end else begin
                    state_d = KS_PRESENT;
                end
            end
            KS_PRESENT: begin
                if (abort) begin
                    state_d = KS_IDLE;
                end else if (rk_ready) begin
                    if (cnt_q == rnd_idx_t'(NUM_ROUNDS)) begin
                        state_d = KS_DONE;
                    end else begin
                        state_d    = KS_STEP;
                        cnt_d      = cnt_q + 4'd1;
                        rcon_adv_s = 1'b1;
                    end
                end else begin
                    state_d = KS_PRESENT;
                end
            end
            KS_DONE: begin
                state_d = KS_IDLE;
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    // Output decode from the registered state, counter and round constant.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        kg_en       = 1'b0;
        kg_gen_key  = 1'b0;
        kg_next_rnd = 1'b0;
        kg_rcon     = 8'h00;
        rk_valid    = 1'b0;
        rk_idx      = 4'd0;
        rk_is_init  = 1'b0;
        case (state_q)
            KS_IDLE: begin
                busy = 1'b0;
            end
            KS_RK0: begin
                busy       = 1'b1;
                rk_valid   = 1'b1;
                rk_is_init = 1'b1;
            end
            KS_STEP: begin
                busy        = 1'b1;
                kg_en       = 1'b1;
                kg_gen_key  = 1'b1;
                kg_rcon     = rcon_s;
                // Round 1 expands straight from the cipher-key input.
                kg_next_rnd = (cnt_q != 4'd1);
            end
            KS_PRESENT: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                rk_idx   = cnt_q;
            end
            KS_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencer for the AES-128 key-generation datapath (aes_key_gen). On a start request it drives the key generator's enable, round-select and round-constant controls through all rounds of expansion. It presents each round key (rounds 0..NUM_ROUNDS) to the cipher core via a valid/ready handshake, stalling expansion while the consumer is not ready. It sits between the top-level AES control and aes_key_gen; the S-box feeding aes_key_gen is combinational (zero latency).

Parameters:
NUM_ROUNDS, 10, number of expansion rounds (AES-128 only; other values unsupported)
RCON_INIT, 8'h01, round constant used for round 1

Ports:
clk  in  1  clock
nrst  in  1  synchronous reset, active low
start  in  1  request a key schedule; sampled only in IDLE
abort  in  1  cancel the schedule in progress; return to IDLE, no done
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after round NUM_ROUNDS key is accepted
kg_en  out  1  pipeline enable to aes_key_gen; one-cycle pulse per round
kg_gen_key  out  1  selects controller rcon in aes_key_gen; high whenever kg_en is high
kg_next_rnd  out  1  0 = expand from the cipher key input, 1 = expand from the registered key
kg_rcon  out  8  round constant for the current round
rk_valid  out  1  round key available to the consumer
rk_ready  in  1  consumer accepts the round key
rk_idx  out  4  index of the presented round key, 0..NUM_ROUNDS
rk_is_init  out  1  high when rk_idx==0 (consumer takes the key from the cipher-key input, not from the key_o register)

Behaviour:
- Clock/reset: one clock clk; reset nrst is synchronous and active-low. When reset is asserted, all state clears at the next edge: state=IDLE, round counter=0, rcon register=RCON_INIT, and every output = 0.
- States: IDLE, RK0, STEP, PRESENT, DONE.
- IDLE: busy=0. If start=1 -> RK0; rcon register <= RCON_INIT; round counter <= 0.
- RK0: rk_valid=1, rk_idx=0, rk_is_init=1. When rk_ready=1 -> STEP, and the round counter <= 1.
- STEP (1 cycle): kg_en=1, kg_gen_key=1, kg_rcon=rcon register.
  - kg_next_rnd=0 when round counter==1; otherwise 1.
  - Next state is PRESENT.
- PRESENT: rk_valid=1, rk_idx=round counter, rk_is_init=0. kg_en=0 while waiting.
  - On rk_ready=1 with round counter==NUM_ROUNDS -> DONE.
  - On rk_ready=1 otherwise -> STEP; round counter +1; rcon <= xtime(rcon).
- xtime: rcon msb=1 -> (rcon<<1)^8'h1B; otherwise rcon<<1, truncated to 8 bits.
  - Required sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- rk_valid, once asserted, stays high with a stable rk_idx until rk_ready. kg_en is never asserted while rk_valid=1.
- Latency with rk_ready tied high: start at cycle 0 gives RK0 at cycle 1, STEP/PRESENT pairs at cycles 2..21, and done at cycle 22.
- start while busy: ignored (no restart).
- abort: takes priority over all transitions in any non-IDLE state, including DONE. Next state is IDLE and outputs are 0 the following cycle; no done pulse. The counter and rcon register reset on the next start.
- abort and start in the same cycle while in IDLE: abort wins; stay in IDLE.
- Outputs are all registered-state decodes. No combinational path from rk_ready to rk_valid; kg_en depends on state only.

Decomposition:
- aes_pkg additions:
  - ks_state_e enum (IDLE, RK0, STEP, PRESENT, DONE)
  - AES_NR=10
  - RCON_INIT=8'h01
  - function xtime(aes_byte)
  - rnd_idx_t (4-bit) typedef
  - Reuse the existing aes_byte.
- Sub-module aes_rcon_gen: the rcon register with load (RCON_INIT) and advance (xtime) controls. It shares clk/nrst and is instantiated once.

Test Plan:
- Reset, then start with rk_ready=1 -> rk_idx sequence 0..10 and kg_rcon at each kg_en = 01,02,04,08,10,20,40,80,1B,36. kg_next_rnd=0 only on the first kg_en. done pulses exactly at cycle 22 after start.
- End-to-end with aes_key_gen and S-box, cipher key 2b7e151628aed2a6abf7158809cf4f3c -> round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6; round-1 key a0fafe1788542cb123a339392a6c7605.
- rk_ready held low 5 cycles at rk_idx=3 -> rk_valid and rk_idx stay stable, no kg_en for those cycles. The schedule resumes and done is delayed by 5 cycles.
- abort asserted in PRESENT at rk_idx=6 -> next cycle busy=0, rk_valid=0, no done. A following start restarts from rk_idx=0 with rcon 01.
- start pulsed during busy at rk_idx=4 -> no effect on sequence or timing.
- nrst low for one cycle mid-schedule (rk_idx=7) -> next cycle all outputs 0 and state IDLE. start=1 held during nrst low is not acted on.
